instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and the buffered
// {pc, instruction} entry handed to decode.
package fetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between memory responses and decode.
// A flush empties the buffer and wins over a push in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop_ready,
   output logic         head_valid,
   output fetch_entry_t head_entry,
   output logic [1:0]   count
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         pop_s;

   // next-state for storage, pointers and occupancy
   always_comb begin
      pop_s    = (count_q != 2'd0) && pop_ready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid = (count_q != 2'd0);
   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the word-addressed fetch PC, keeps one memory request in
// flight, and buffers returned words for decode. Redirects flush everything.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc
);

   localparam logic [1:0] DEPTH_L = 2'(FIFO_DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            req_s;
   logic            push_s;
   logic            flush_s;
   logic [1:0]      fifo_count_s;
   fetch_entry_t    push_entry_s;
   fetch_entry_t    head_s;

   // request gating, FSM transitions and fetch PC update; redirect wins over all
   always_comb begin
      req_s        = (state_q == REQ) && (fifo_count_s < DEPTH_L) && !redirect && !reset;
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      push_s       = 1'b0;
      flush_s      = 1'b0;
      push_entry_s = '{pc: req_pc_q, instr: imem_rdata};
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         flush_s    = 1'b1;
         case (state_q)
            WAIT:    state_d = imem_rvalid ? REQ : DROP;
            DROP:    state_d = imem_rvalid ? REQ : DROP;
            default: state_d = REQ;
         endcase
      end else begin
         case (state_q)
            REQ: begin
               if (req_s && imem_gnt) begin
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd1;
                  state_d    = WAIT;
               end else begin
                  state_d = REQ;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  push_s  = 1'b1;
                  state_d = REQ;
               end else begin
                  state_d = WAIT;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state_d = REQ;
               end else begin
                  state_d = DROP;
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

   // FSM and address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_fifo u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_s),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop_ready  (instr_ready),
      .head_valid (instr_valid),
      .head_entry (head_s),
      .count      (fifo_count_s)
   );

   assign imem_req   = req_s;
   assign imem_addr  = req_s ? fetch_pc_q : 32'h0000_0000;
   assign instr_pc   = head_s.pc;
   assign instr_data = head_s.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a variable-latency memory model plus
// a queue of expected {pc, instr} pairs popped at each decode handshake.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic        w_instr_valid;
   logic [31:0] w_instr_data;
   logic [31:0] w_instr_pc;

   logic [63:0] exp_q[$];
   int          pop_cyc[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          gnt_budget = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = 32'h0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .FIFO_DEPTH(2)) dut_w (
      .clk(clk), .reset(reset), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(1'b0),
      .imem_rvalid(1'b0), .imem_rdata(32'h0),
      .instr_valid(w_instr_valid), .instr_ready(1'b0),
      .instr_data(w_instr_data), .instr_pc(w_instr_pc)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Memory model: grants while budget remains, answers mem_lat cycles after gnt.
   initial begin
      logic        fire;
      logic [31:0] fa;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         fire = imem_req && imem_gnt;
         fa   = imem_addr;
         #1;
         imem_rvalid = 1'b0;
         if (fire) begin
            mem_pend = 1'b1;
            mem_addr = fa;
            mem_cnt  = mem_lat - 1;
            gnt_budget--;
         end
         if (mem_pend) begin
            if (mem_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = 32'hA000 + mem_addr;
               mem_pend    = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
         imem_gnt = (gnt_budget > 0);
      end
   end

   // Scoreboard: every decode handshake must match the oldest expectation.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!reset && instr_valid && instr_ready) begin
            pop_cyc.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pop: got pc=%h data=%h, required no instruction", instr_pc, instr_data);
            end else begin
               e = exp_q.pop_front();
               if ({instr_pc, instr_data} !== e) begin
                  n_err++;
                  $display("FAIL instr_out: got pc=%h data=%h, required pc=%h data=%h",
                           instr_pc, instr_data, e[63:32], e[31:0]);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      redirect    = 1'b0;
      instr_ready = 1'b0;
      gnt_budget  = 0;
      mem_pend    = 1'b0;
      mem_lat     = 1;
      exp_q.delete();
      pop_cyc.delete();
      step();
      step();
   endtask

   task automatic drain(input int max_cycles);
      for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) step();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b, required 0", imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h, required 0", imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
      n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h, required 0", instr_pc); end
      n_cmp++; if (instr_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h, required 0", instr_data); end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      reset       = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back({32'(i), 32'hA000 + 32'(i)});
      gnt_budget = 4;
      drain(40);
      step();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_drain: %0d left, required 0", exp_q.size()); end
      n_cmp++;
      if (pop_cyc.size() != 4) begin
         n_err++; $display("FAIL stream_count: got %0d pops, required 4", pop_cyc.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
               n_err++; $display("FAIL stream_rate: gap %0d cycles, required 2", pop_cyc[i] - pop_cyc[i-1]);
            end
         end
      end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
         n_err++; $display("FAIL stream_next_addr: got req=%b addr=%h, required req=1 addr=4", imem_req, imem_addr);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back({32'(i), 32'hA000 + 32'(i)});
      gnt_budget = 5;
      repeat (12) step();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr_data !== 32'hA000) begin
         n_err++; $display("FAIL bp_head: got v=%b pc=%h data=%h, required v=1 pc=0 data=a000", instr_valid, instr_pc, instr_data);
      end
      n_cmp++; if (gnt_budget != 3) begin n_err++; $display("FAIL bp_grants: got %0d grants, required 2", 5 - gnt_budget); end
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_held: got %b, required 0", imem_req); end
      end
      instr_ready = 1'b1;
      drain(60);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      reset       = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back({32'(i), 32'hA000 + 32'(i)});
      gnt_budget = 5;
      drain(40);
      mem_lat    = 3;
      gnt_budget = 1;
      for (int k = 0; k < 20 && !mem_pend; k++) step();
      n_cmp++; if (!mem_pend || mem_addr !== 32'd5) begin
         n_err++; $display("FAIL rw_pending: got pend=%b addr=%h, required pend=1 addr=5", mem_pend, mem_addr);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      exp_q.push_back({32'h40, 32'hA040});
      exp_q.push_back({32'h41, 32'hA041});
      gnt_budget = 2;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req_forced: got %b, required 0", imem_req); end
      step();
      redirect = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_valid_after: got %b, required 0", instr_valid); end
      step();
      n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_err++; $display("FAIL rw_drop: got v=%b req=%b, required v=0 req=0", instr_valid, imem_req);
      end
      drain(60);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rw_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      reset       = 1'b0;
      instr_ready = 1'b1;
      mem_lat     = 3;
      gnt_budget  = 1;
      for (int k = 0; k < 20 && !imem_rvalid; k++) step();
      n_cmp++; if (imem_rvalid !== 1'b1) begin n_err++; $display("FAIL rr_rvalid_seen: got %b, required 1", imem_rvalid); end
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      mem_lat     = 1;
      gnt_budget  = 1;
      exp_q.push_back({32'h40, 32'hA040});
      step();
      redirect = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_err++; $display("FAIL rr_next_req: got req=%b addr=%h, required req=1 addr=40", imem_req, imem_addr);
      end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rr_valid: got %b, required 0", instr_valid); end
      drain(40);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      reset      = 1'b0;
      gnt_budget = 1;
      for (int k = 0; k < 20 && !instr_valid; k++) step();
      mem_lat    = 4;
      gnt_budget = 1;
      for (int k = 0; k < 20 && !mem_pend; k++) step();
      n_cmp++; if (instr_valid !== 1'b1 || !mem_pend) begin
         n_err++; $display("FAIL rm_setup: got v=%b pend=%b, required v=1 pend=1", instr_valid, mem_pend);
      end
      reset = 1'b1;
      step();
      n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_err++; $display("FAIL rm_reset_out: got v=%b req=%b, required 0 0", instr_valid, imem_req);
      end
      reset       = 1'b0;
      instr_ready = 1'b1;
      repeat (6) step();
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_late_rvalid: got v=%b, required 0", instr_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_err++; $display("FAIL rm_first_addr: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
      n_cmp++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL rm_reset_pc_param: got req=%b addr=%h, required req=1 addr=ffffffff", w_imem_req, w_imem_addr);
      end
      n_cmp++; if (w_instr_valid !== 1'b0 || w_instr_pc !== 32'h0 || w_instr_data !== 32'h0) begin
         n_err++; $display("FAIL rm_param_outs: got v=%b pc=%h data=%h, required 0", w_instr_valid, w_instr_pc, w_instr_data);
      end
      mem_lat = 1;
      exp_q.push_back({32'h0, 32'hA000});
      gnt_budget = 1;
      drain(20);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rm_drain: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      logic [31:0] top_pc;
      top_pc = 32'hFFFF_FFFF;
      do_reset();
      reset       = 1'b0;
      instr_ready = 1'b1;
      step();
      redirect    = 1'b1;
      redirect_pc = top_pc;
      step();
      redirect = 1'b0;
      exp_q.push_back({top_pc, 32'hA000 + top_pc});
      exp_q.push_back({32'h0, 32'hA000});
      gnt_budget = 2;
      drain(40);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: %0d left, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rvalid();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
